// File: rtl/ofs_fim_pcie_ss_rxcrdt_accum_if.sv
// Release events into the RX credit accumulator and the rxcrdt messages it emits.
// master drives releases and consumes messages; slave is the accumulator.
interface ofs_fim_pcie_ss_rxcrdt_accum_if;
  logic        rel_valid;
  logic        rel_is_cpl;
  logic [7:0]  rel_data_cr;
  logic        rxcrdt_tvalid;
  logic [18:0] rxcrdt_tdata;

  modport master (
    output rel_valid, rel_is_cpl, rel_data_cr,
    input  rxcrdt_tvalid, rxcrdt_tdata
  );

  modport slave (
    input  rel_valid, rel_is_cpl, rel_data_cr,
    output rxcrdt_tvalid, rxcrdt_tdata
  );
endinterface

// File: rtl/ofs_fim_pcie_ss_rxcrdt_accum.sv
// RX credit return: accumulates released hdr/data credits per class, returns one rxcrdt message per cycle.
// Release-to-message latency 2 cycles; no back-pressure on rxcrdt, the HIP must always accept.
module ofs_fim_pcie_ss_rxcrdt_accum #(
  parameter int INIT_CPL_HDR  = 64,
  parameter int INIT_CPL_DATA = 1024,
  parameter int INIT_REQ_HDR  = 64,
  parameter int INIT_REQ_DATA = 1024,
  parameter int MAX_RET       = 255,
  parameter int CNT_W         = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 link_up,
  ofs_fim_pcie_ss_rxcrdt_accum_if.slave        bus,
  output logic                                 err_overflow
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] init_val [4];
  logic [CNT_W-1:0] acc_q    [4];
  logic [CNT_W-1:0] acc_d    [4];
  logic [CNT_W-1:0] add_v    [4];
  logic [CNT_W-1:0] sub_v    [4];
  logic [CNT_W:0]   sum_v    [4];
  logic [1:0]       ptr_q;
  logic [1:0]       sel;
  logic [1:0]       idx;
  logic             found;
  logic             ret_en;
  logic             link_drop;
  logic             ovf_d;
  logic [CNT_W-1:0] sel_cnt;

  // Accumulator order matches the message type code: cpl_hdr, cpl_data, req_hdr, req_data.
  assign init_val[0] = CNT_W'(INIT_CPL_HDR);
  assign init_val[1] = CNT_W'(INIT_CPL_DATA);
  assign init_val[2] = CNT_W'(INIT_REQ_HDR);
  assign init_val[3] = CNT_W'(INIT_REQ_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (link_up)  state_d = RUN;
      RUN:     if (!link_up) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ret_en    = (state_q == RUN) && link_up;
  assign link_drop = (state_q == RUN) && !link_up;

  // Walk downward so the lowest offset from the pointer wins.
  always_comb begin
    found   = 1'b0;
    sel     = ptr_q;
    idx     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (acc_q[idx] != '0) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    sel_cnt = acc_q[sel];
    if (32'(acc_q[sel]) > 32'(MAX_RET)) sel_cnt = CNT_W'(MAX_RET);
  end

  always_comb begin
    ovf_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      add_v[i] = '0;
      sub_v[i] = '0;
    end
    if (bus.rel_valid) begin
      if (bus.rel_is_cpl) begin
        add_v[0] = CNT_W'(1);
        add_v[1] = CNT_W'(bus.rel_data_cr);
      end else begin
        add_v[2] = CNT_W'(1);
        add_v[3] = CNT_W'(bus.rel_data_cr);
      end
    end
    if (ret_en && found) sub_v[sel] = sel_cnt;
    // One extra bit so a release landing on a nearly full counter is caught, not wrapped.
    for (int i = 0; i < 4; i++) begin
      sum_v[i] = {1'b0, acc_q[i]} - {1'b0, sub_v[i]} + {1'b0, add_v[i]};
      acc_d[i] = sum_v[i][CNT_W-1:0];
      if (link_drop) begin
        acc_d[i] = init_val[i];
      end else if (sum_v[i][CNT_W]) begin
        acc_d[i] = '1;
        ovf_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) acc_q[i] <= init_val[i];
      ptr_q             <= 2'b00;
      err_overflow      <= 1'b0;
      bus.rxcrdt_tvalid <= 1'b0;
      bus.rxcrdt_tdata  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
      err_overflow <= err_overflow | ovf_d;
      if (link_drop) begin
        ptr_q             <= 2'b00;
        bus.rxcrdt_tvalid <= 1'b0;
      end else if (ret_en && found) begin
        ptr_q             <= sel + 2'd1;
        bus.rxcrdt_tvalid <= 1'b1;
        bus.rxcrdt_tdata  <= {sel, 1'b0, 16'(sel_cnt)};
      end else begin
        bus.rxcrdt_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rxcrdt_accum.sv
// Scoreboard bench for the RX credit accumulator: default instance plus a narrow instance for saturation.
module tb_ofs_fim_pcie_ss_rxcrdt_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic link_up = 1'b0;
  logic link_up2 = 1'b0;
  logic err_ovf, err_ovf2;

  always #5 clk = ~clk;

  ofs_fim_pcie_ss_rxcrdt_accum_if bus1();
  ofs_fim_pcie_ss_rxcrdt_accum_if bus2();

  ofs_fim_pcie_ss_rxcrdt_accum dut (
    .clk          (clk),
    .rst          (rst),
    .link_up      (link_up),
    .bus          (bus1),
    .err_overflow (err_ovf)
  );

  ofs_fim_pcie_ss_rxcrdt_accum #(
    .INIT_CPL_HDR  (1),
    .INIT_CPL_DATA (250),
    .INIT_REQ_HDR  (0),
    .INIT_REQ_DATA (0),
    .MAX_RET       (255),
    .CNT_W         (8)
  ) dut_narrow (
    .clk          (clk),
    .rst          (rst),
    .link_up      (link_up2),
    .bus          (bus2),
    .err_overflow (err_ovf2)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [18:0] exp_q [$];
  logic [18:0] mon_exp;
  int          sum_t [4];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [18:0] msg(input logic [1:0] t, input int c);
    return {t, 1'b0, 16'(c)};
  endfunction

  task automatic push(input logic [1:0] t, input int c);
    exp_q.push_back(msg(t, c));
  endtask

  // Initial advertisement with default data inits; cpl_hdr and last cpl_data vary with idle releases.
  task automatic push_init(input int ch, input int cd_last);
    push(2'b00, ch);
    push(2'b01, 255);
    push(2'b10, 64);
    push(2'b11, 255);
    for (int i = 0; i < 3; i++) begin
      push(2'b01, 255);
      push(2'b11, 255);
    end
    push(2'b01, cd_last);
    push(2'b11, 4);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check_val("drain_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus1.rxcrdt_tvalid) begin
      sum_t[bus1.rxcrdt_tdata[18:17]] += int'(bus1.rxcrdt_tdata[15:0]);
      if (exp_q.size() == 0) begin
        check_val("extra_msg", {12'b0, bus1.rxcrdt_tvalid, bus1.rxcrdt_tdata}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_val("msg", 32'(bus1.rxcrdt_tdata), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int base_a, base_b;
    logic seen;
    for (int i = 0; i < 4; i++) sum_t[i] = 0;
    bus1.rel_valid = 1'b0; bus1.rel_is_cpl = 1'b0; bus1.rel_data_cr = 8'd0;
    bus2.rel_valid = 1'b0; bus2.rel_is_cpl = 1'b0; bus2.rel_data_cr = 8'd0;

    // Reset values
    repeat (2) @(negedge clk);
    check_val("rst_tvalid", 32'(bus1.rxcrdt_tvalid), 0);
    check_val("rst_tdata", 32'(bus1.rxcrdt_tdata), 0);
    check_val("rst_err", 32'(err_ovf), 0);
    check_val("rst_err2", 32'(err_ovf2), 0);
    tick;
    rst = 1'b0;
    repeat (3) tick;
    check_val("idle_no_msg", 32'(bus1.rxcrdt_tvalid), 0);

    // 1: link-up advertisement and its latency
    link_up = 1'b1;
    push_init(64, 4);
    @(negedge clk);
    @(negedge clk);
    check_val("lu_lat0", 32'(bus1.rxcrdt_tvalid), 0);
    @(negedge clk);
    check_val("lu_lat1", 32'(bus1.rxcrdt_tvalid), 1);
    wait_drain;

    // 2: single completion release, 2-cycle latency
    tick;
    bus1.rel_valid = 1'b1; bus1.rel_is_cpl = 1'b1; bus1.rel_data_cr = 8'd3;
    push(2'b00, 1);
    push(2'b01, 3);
    tick;
    bus1.rel_valid = 1'b0;
    @(negedge clk);
    check_val("rel_c1_vld", 32'(bus1.rxcrdt_tvalid), 0);
    @(negedge clk);
    check_val("rel_c2_vld", 32'(bus1.rxcrdt_tvalid), 1);
    check_val("rel_c2_dat", 32'(bus1.rxcrdt_tdata), 32'(msg(2'b00, 1)));
    @(negedge clk);
    check_val("rel_c3_dat", 32'(bus1.rxcrdt_tdata), 32'(msg(2'b01, 3)));
    @(negedge clk);
    check_val("rel_c4_vld", 32'(bus1.rxcrdt_tvalid), 0);
    wait_drain;

    // 3: header-only request stream
    base_a = sum_t[2];
    base_b = sum_t[0] + sum_t[1] + sum_t[3];
    tick;
    bus1.rel_valid = 1'b1; bus1.rel_is_cpl = 1'b0; bus1.rel_data_cr = 8'd0;
    for (int i = 0; i < 10; i++) push(2'b10, 1);
    repeat (9) tick;
    tick;
    bus1.rel_valid = 1'b0;
    wait_drain;
    check_val("s3_hdr_sum", sum_t[2] - base_a, 10);
    check_val("s3_other", sum_t[0] + sum_t[1] + sum_t[3] - base_b, 0);

    // 4: link drop mid-advertisement, then full restart
    tick;
    link_up = 1'b0;
    tick;
    link_up = 1'b1;
    push_init(64, 4);
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 3; i++) begin
      @(negedge clk);
      if (bus1.rxcrdt_tvalid) cnt++;
    end
    check_val("s4_three", cnt, 3);
    #1;
    link_up = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_val("s4_drop", 32'(bus1.rxcrdt_tvalid), 0);
    link_up = 1'b1;
    push_init(64, 4);
    wait_drain;

    // 5: releases accumulate while idle
    tick;
    link_up = 1'b0;
    tick;
    bus1.rel_valid = 1'b1; bus1.rel_is_cpl = 1'b1; bus1.rel_data_cr = 8'd2;
    repeat (4) tick;
    tick;
    bus1.rel_valid = 1'b0;
    link_up = 1'b1;
    base_a = sum_t[1];
    push_init(69, 14);
    wait_drain;
    check_val("s5_cd_sum", sum_t[1] - base_a, 1034);

    // Asynchronous reset while a message is on the bus
    tick;
    link_up = 1'b0;
    tick;
    tick;
    link_up = 1'b1;
    push(2'b00, 64);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus1.rxcrdt_tvalid) seen = 1'b1;
    end
    check_val("arst_seen", 32'(seen), 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_tvalid", 32'(bus1.rxcrdt_tvalid), 0);
    check_val("arst_tdata", 32'(bus1.rxcrdt_tdata), 0);
    exp_q.delete();
    link_up = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    repeat (2) tick;

    // 6: saturation on the narrow instance
    check_val("s6_err_pre", 32'(err_ovf2), 0);
    bus2.rel_valid = 1'b1; bus2.rel_is_cpl = 1'b1; bus2.rel_data_cr = 8'd10;
    tick;
    bus2.rel_valid = 1'b0;
    @(negedge clk);
    check_val("s6_err_set", 32'(err_ovf2), 1);
    tick;
    link_up2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus2.rxcrdt_tvalid) seen = 1'b1;
    end
    check_val("s6_first_v", 32'(seen), 1);
    check_val("s6_hdr", 32'(bus2.rxcrdt_tdata), 32'(msg(2'b00, 2)));
    @(negedge clk);
    check_val("s6_data_v", 32'(bus2.rxcrdt_tvalid), 1);
    check_val("s6_data", 32'(bus2.rxcrdt_tdata), 32'(msg(2'b01, 255)));
    @(negedge clk);
    check_val("s6_done", 32'(bus2.rxcrdt_tvalid), 0);
    tick;
    link_up2 = 1'b0;
    repeat (3) tick;
    check_val("s6_err_idle", 32'(err_ovf2), 1);
    link_up2 = 1'b1;
    repeat (3) tick;
    check_val("s6_err_run", 32'(err_ovf2), 1);
    check_val("main_no_ovf", 32'(err_ovf), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
